// File: rtl/tri_pixel_map.sv
// tri_pixel_map: captures rasterizer points into a 2^W x 2^W bitmap, counts
// distinct covered pixels, then streams the finished frame out one row per
// rd_en and clears itself for the next triangle.

// One bitmap row: sticky set of a single bit, bulk clear at end of readout.
module tri_pixel_row #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           set,
  input  logic [W-1:0]   x,
  input  logic           clr,
  output logic [(1<<W)-1:0] bits
);
  // Row storage: clear has priority so a frame never leaks into the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      bits    <= '0;
    else if (clr)    bits    <= '0;
    else if (set)    bits[x] <= 1'b1;
  end
endmodule

module tri_pixel_map #(
  parameter int W     = 3,
  parameter int CNT_W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 busy_in,
  input  logic                 po,
  input  logic [W-1:0]         xo,
  input  logic [W-1:0]         yo,
  input  logic                 rd_en,
  output logic                 frame_valid,
  output logic                 row_vld,
  output logic [W-1:0]         row_idx,
  output logic [(1<<W)-1:0]    row_data,
  output logic [CNT_W-1:0]     pix_cnt,
  output logic                 overrun
);
  localparam int N = 1 << W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(N * N);

  typedef enum logic [1:0] {IDLE, CAPT, READ} state_t;

  state_t             state, state_nxt;
  logic [N-1:0][N-1:0] map;
  logic [W-1:0]       rd_ptr;
  logic               cap, hit, last;

  // Points are accepted in IDLE (first busy edge) and CAPT; READ drops them.
  assign cap  = busy_in & po & (state != READ);
  assign hit  = map[yo][xo];
  assign last = (state == READ) & rd_en & (rd_ptr == W'(N - 1));

  // frame_valid follows the state so reset drops it asynchronously and it
  // falls on the same edge that issues the final row.
  assign frame_valid = (state == READ);

  for (genvar r = 0; r < N; r++) begin : g_row
    tri_pixel_row #(.W(W)) u_row (
      .clk   (clk),
      .reset (reset),
      .set   (cap && (yo == W'(r))),
      .x     (xo),
      .clr   (last),
      .bits  (map[r])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: IDLE -> CAPT on busy, CAPT -> READ when busy drops,
  // READ -> IDLE once the last row has been issued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (busy_in)  state_nxt = CAPT;
      CAPT:    if (!busy_in) state_nxt = READ;
      READ:    if (last)     state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Distinct-pixel counter: only a 0->1 transition counts; saturates at N*N.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                pix_cnt <= '0;
    else if (last)                             pix_cnt <= '0;
    else if (cap && !hit && pix_cnt < MAX_CNT) pix_cnt <= pix_cnt + 1'b1;
  end

  // Row readout: one registered row per rd_en; outputs hold through stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      row_vld  <= 1'b0;
      row_idx  <= '0;
      row_data <= '0;
    end else if (state == READ && rd_en) begin
      row_vld  <= 1'b1;
      row_idx  <= rd_ptr;
      row_data <= map[rd_ptr];
      rd_ptr   <= last ? '0 : rd_ptr + 1'b1;
    end else begin
      row_vld  <= 1'b0;
    end
  end

  // Sticky overrun: rasterizer started a new triangle before readout finished.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        overrun <= 1'b0;
    else if (state == READ && busy_in) overrun <= 1'b1;
  end
endmodule

// File: tb/tb_tri_pixel_map.sv
// Directed bench for tri_pixel_map with a small bitmap scoreboard.
module tb_tri_pixel_map;
  localparam int W = 3, CNT_W = 7;

  logic clk = 1'b0, reset = 1'b0;
  logic busy_in = 1'b0, po = 1'b0, rd_en = 1'b0;
  logic [W-1:0] xo = '0, yo = '0;
  logic frame_valid, row_vld, overrun;
  logic [W-1:0] row_idx;
  logic [7:0] row_data;
  logic [CNT_W-1:0] pix_cnt;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] sb [8];
  int exp_cnt;
  int max_cnt;

  tri_pixel_map #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .busy_in(busy_in), .po(po), .xo(xo), .yo(yo),
    .rd_en(rd_en), .frame_valid(frame_valid), .row_vld(row_vld),
    .row_idx(row_idx), .row_data(row_data), .pix_cnt(pix_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_clear();
    for (int i = 0; i < 8; i++) sb[i] = 8'h00;
    exp_cnt = 0;
    max_cnt = 0;
  endtask

  // Capture one point: drive on negedge, sampled on the following posedge.
  task automatic pt(input int x, input int y);
    @(negedge clk);
    busy_in = 1'b1; po = 1'b1; xo = W'(x); yo = W'(y);
    if (!sb[y][x]) begin sb[y][x] = 1'b1; exp_cnt++; end
    @(posedge clk); #1;
    if (int'(pix_cnt) > max_cnt) max_cnt = int'(pix_cnt);
  endtask

  task automatic busy_nopt();
    @(negedge clk);
    busy_in = 1'b1; po = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic end_frame(input string tag);
    @(negedge clk);
    busy_in = 1'b0; po = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_fv"}, frame_valid, 1);
    chk({tag, "_cnt"}, pix_cnt, exp_cnt);
  endtask

  // Read rows first..last with rd_en held high.
  task automatic read_rows(input string tag, input int first, input int last);
    @(negedge clk);
    rd_en = 1'b1;
    for (int r = first; r <= last; r++) begin
      @(posedge clk); #1;
      chk({tag, "_vld"}, row_vld, 1);
      chk({tag, "_idx"}, row_idx, r);
      chk({tag, "_row"}, row_data, sb[r]);
      chk({tag, "_fv_rd"}, frame_valid, (r == 7) ? 0 : 1);
      if (r == 7) chk({tag, "_cnt_clr"}, pix_cnt, 0);
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int issued, got;
    logic prev;

    // Reset state
    #12;
    chk("rst_fv", frame_valid, 0);
    chk("rst_vld", row_vld, 0);
    chk("rst_idx", row_idx, 0);
    chk("rst_data", row_data, 0);
    chk("rst_cnt", pix_cnt, 0);
    chk("rst_ovr", overrun, 0);
    @(negedge clk); reset = 1'b1;

    // Reset mid-capture after 5 points
    sb_clear();
    pt(0, 0); pt(1, 0); pt(2, 1); pt(3, 2); pt(7, 7);
    chk("mid_cnt", pix_cnt, 5);
    #1 reset = 1'b0; busy_in = 1'b0; po = 1'b0;
    #1;
    chk("mid_rst_cnt", pix_cnt, 0);
    chk("mid_rst_fv", frame_valid, 0);
    chk("mid_rst_vld", row_vld, 0);
    chk("mid_rst_data", row_data, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_fv", frame_valid, 0);
    sb_clear();
    busy_nopt();
    end_frame("zero");
    read_rows("zero", 0, 7);

    // Single point (2,5) inside a 3-cycle busy window
    sb_clear();
    busy_nopt(); pt(2, 5); busy_nopt();
    end_frame("single");
    chk("single_row5_exp", sb[5], 8'h04);
    read_rows("single", 0, 7);

    // Triangle (0,0),(4,0),(0,4): covered pixels have x+y <= 4
    sb_clear();
    for (int y = 0; y <= 4; y++)
      for (int x = 0; x + y <= 4; x++) pt(x, y);
    end_frame("tri");
    chk("tri_cnt15", pix_cnt, 15);
    read_rows("tri", 0, 7);

    // Duplicates then every coordinate; count must stop at 64
    sb_clear();
    for (int i = 0; i < 4; i++) pt(3, 3);
    chk("dup_cnt", pix_cnt, 1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) pt(x, y);
    chk("sat_max", max_cnt, 64);
    end_frame("sat");
    read_rows("sat", 0, 7);

    // Stalled readout: rd_en 1,0,0,1,0,0,...
    sb_clear();
    pt(0, 0); pt(7, 7); pt(4, 3);
    end_frame("stall");
    issued = 0; got = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      rd_en = (cyc % 3 == 0) && (issued < 8);
      prev = rd_en;
      if (rd_en) issued++;
      @(posedge clk); #1;
      chk("stall_vld", row_vld, prev);
      if (prev) begin
        chk("stall_idx", row_idx, got);
        chk("stall_row", row_data, sb[got]);
        chk("stall_fv", frame_valid, (got == 7) ? 0 : 1);
        got++;
      end
    end
    @(negedge clk); rd_en = 1'b0;
    chk("stall_rows", got, 8);

    // Overrun during readout after 3 rows
    sb_clear();
    pt(2, 2); pt(5, 6);
    end_frame("ovr");
    read_rows("ovr_a", 0, 2);
    @(negedge clk); busy_in = 1'b1; po = 1'b1; xo = 3'd1; yo = 3'd1;
    @(posedge clk); #1;
    chk("ovr_flag", overrun, 1);
    chk("ovr_cnt", pix_cnt, 2);
    chk("ovr_fv", frame_valid, 1);
    @(negedge clk); xo = 3'd1; yo = 3'd6;
    @(posedge clk); #1;
    @(negedge clk); busy_in = 1'b0; po = 1'b0;
    read_rows("ovr_b", 3, 7);
    chk("ovr_sticky", overrun, 1);
    @(negedge clk); reset = 1'b0;
    #1 chk("ovr_rst", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/tri_pixel_map.md
# tri_pixel_map

Downstream capture stage for the triangle rasterizer. Samples the rasterizer's point stream (`po`, `xo`, `yo`, `busy`) into an 8x8 bitmap and counts distinct covered pixels. When the rasterizer drops `busy`, the block presents the finished frame and streams it out one row per handshake. It then clears itself for the next triangle.

## Interface
Parameters:
- `W`, 3: coordinate width; map is 2^W x 2^W (8x8).
- `CNT_W`, 7: pixel counter width; must hold 2^(2W) = 64.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-low. Low clears all state and outputs immediately.
- `busy_in` input 1: rasterizer `busy`.
- `po` input 1: rasterizer point-valid.
- `xo` input W: rasterizer point x.
- `yo` input W: rasterizer point y.
- `rd_en` input 1: consumer requests the next row.
- `frame_valid` output 1: the captured frame is complete and readable.
- `row_vld` output 1: `row_data` and `row_idx` are valid this cycle.
- `row_idx` output W: index (y) of the row on `row_data`.
- `row_data` output 2^W: bit i is pixel (x=i, y=row_idx).
- `pix_cnt` output CNT_W: number of distinct pixels set in the current frame.
- `overrun` output 1: sticky; `busy_in` rose while a frame was still unread.

## Operation
- Storage: 8 rows x 8 bits. All bits are 0 after reset and after each completed readout.
- FSM with three states; reset state is IDLE.
  - IDLE: `frame_valid`=0. On a posedge with `busy_in`=1, go to CAPT. If `po`=1 on that same edge, capture the point as in CAPT.
  - CAPT: on each posedge with `busy_in`=1 and `po`=1, set map[`yo`][`xo`].
    - If that bit was 0, increment `pix_cnt` by 1.
    - If the bit was already 1, leave the map and counter unchanged; duplicates are not counted.
    - When `busy_in`=0 at a posedge, go to READ. A `po` arriving with `busy_in`=0 is ignored.
  - READ: `frame_valid`=1. Internal read pointer `rd_ptr` starts at 0.
    - On each posedge with `rd_en`=1, register `row_data`=map[`rd_ptr`], `row_idx`=`rd_ptr`, `row_vld`=1, then increment `rd_ptr`.
    - On a posedge with `rd_en`=0, `row_vld`=0 on the next cycle; `row_data` and `row_idx` hold.
    - On the edge that issues row 7: clear the map, clear `pix_cnt`, reset `rd_ptr` to 0, go to IDLE.
    - `frame_valid` falls in the same cycle that row 7 appears on `row_vld`.
- Overrun: if `busy_in`=1 at any posedge while in READ, set `overrun`=1 and drop all points. `overrun` clears only on reset.
- `pix_cnt` saturates at 64; it cannot exceed the map size.
- Reset low at any time, including mid-capture or mid-readout: the state returns to IDLE, the map is cleared, and every output returns to 0 asynchronously.

## Timing
- Reset values: `frame_valid`=0, `row_vld`=0, `row_idx`=0, `row_data`=0, `pix_cnt`=0, `overrun`=0.
- The rasterizer updates `xo`/`yo`/`po`/`busy` on negedge. This block samples on posedge, so inputs are stable half a cycle before sampling. No input synchronisation is required.
- Capture latency: a point sampled at posedge N is in the map, and reflected in `pix_cnt`, after posedge N.
- Frame completion: the first posedge with `busy_in`=0 after CAPT is edge M. `frame_valid`=1 from just after edge M.
- Read latency: 1 cycle. `rd_en` high at edge K gives `row_vld`=1 during cycle K..K+1.
- Minimum readout is 8 cycles with `rd_en` held high. Gaps in `rd_en` stall the readout without losing rows.
- Back-to-back frames: a new frame can be captured starting from the cycle after row 7 is issued.

## Test plan
- Reset: drive `reset`=0 mid-CAPT after 5 points. Required: all outputs 0 immediately; after release, state IDLE, `pix_cnt`=0, map reads all zero on the next frame.
- Single point: `busy_in` high for 3 cycles with one `po` at (x=2,y=5), then `busy_in` low. Required: `frame_valid`=1, `pix_cnt`=1. Readout with `rd_en` held gives rows 0-4=0x00, row 5=0x04, rows 6-7=0x00, with `row_idx` 0..7 on consecutive cycles.
- Full triangle: drive the rasterizer sequence for vertices (0,0),(4,0),(0,4). Required: `pix_cnt` equals the count of `po` pulses. Each row's bits match the scoreboard built from the `po` points.
- Duplicate and saturation: send (3,3) four times, then all 64 coordinates. Required: `pix_cnt`=1 after the duplicates and 64 at the end, never 65. All rows read 0xFF.
- Stalled readout: toggle `rd_en` 1,0,0,1,… Required: `row_vld` only on the cycle after each `rd_en`=1, `row_idx` strictly increments, and exactly 8 rows are delivered. `frame_valid` falls with row 7.
- Overrun: raise `busy_in` with `po`=1 at (1,1) during READ after 3 rows. Required: `overrun`=1, remaining rows unchanged, no bit set at (1,1), `pix_cnt` unchanged.
